// File: rtl/conv_pkg.sv
// Shared types, default sizes and width helpers for the streaming convolution engine.
// These are used by the RTL and by the bench's golden model.
package conv_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} conv_state_e;

   localparam int DEF_KERNELS    = 3;
   localparam int DEF_KH         = 3;
   localparam int DEF_KW         = 3;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_IMAGE_ROWS = 28;
   localparam int DEF_IMAGE_COLS = 28;
   localparam int DEF_STRIDE     = 1;

   function automatic int acc_width(int dw, int taps);
      return 2*dw + $clog2(taps);
   endfunction

   // Index widths never collapse to zero bits, even for one-entry ranges.
   function automatic int clog2_1(int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int out_dim(int img, int k, int stride);
      return (img - k) / stride + 1;
   endfunction
endpackage

// File: rtl/conv_stream_engine_if.sv
// Pixel-in / result-out stream bundle of the convolution engine.
// The slave side is the engine; the master side is the DMA/consumer pair.
interface conv_stream_engine_if #(
   parameter int DATA_WIDTH = 32,
   parameter int KERNELS    = 3,
   parameter int ROW_W      = 5,
   parameter int COL_W      = 5
);
   logic                          pix_valid;
   logic                          pix_ready;
   logic [DATA_WIDTH-1:0]         pix_data;
   logic                          out_valid;
   logic                          out_ready;
   logic [KERNELS*DATA_WIDTH-1:0] out_data;
   logic [ROW_W-1:0]              out_row;
   logic [COL_W-1:0]              out_col;

   modport master (output pix_valid, pix_data, out_ready,
                   input  pix_ready, out_valid, out_data, out_row, out_col);
   modport slave  (input  pix_valid, pix_data, out_ready,
                   output pix_ready, out_valid, out_data, out_row, out_col);
endinterface

// File: rtl/conv_line_buffer.sv
// KH-1 row buffers plus a KH x KW window; win_next is the window as it will look
// after the current pixel shifts in, so the MAC can load its result on the accept edge.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int KH         = 3,
   parameter int KW         = 3,
   parameter int DATA_WIDTH = 32,
   parameter int IMAGE_COLS = 28
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               shift,
   input  logic [clog2_1(IMAGE_COLS)-1:0]     col,
   input  logic [DATA_WIDTH-1:0]              pix,
   output logic [KH*KW-1:0][DATA_WIDTH-1:0]   win_next
);
   // rows[0] holds the previous image row, rows[KH-2] the oldest one.
   logic [DATA_WIDTH-1:0]          rows [KH-1][IMAGE_COLS];
   logic [DATA_WIDTH-1:0]          win  [KH][KW];
   logic [KH-1:0][DATA_WIDTH-1:0]  column;

   always_comb begin
      column   = '0;
      win_next = '0;
      for (int r = 0; r < KH-1; r++) column[r] = rows[KH-2-r][col];
      column[KH-1] = pix;
      for (int r = 0; r < KH; r++) begin
         for (int j = 0; j < KW-1; j++) win_next[r*KW+j] = win[r][j+1];
         win_next[r*KW+KW-1] = column[r];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < KH-1; k++)
            for (int c = 0; c < IMAGE_COLS; c++) rows[k][c] <= '0;
         for (int r = 0; r < KH; r++)
            for (int j = 0; j < KW; j++) win[r][j] <= '0;
      end else if (shift) begin
         rows[0][col] <= pix;
         for (int k = 1; k < KH-1; k++) rows[k][col] <= rows[k-1][col];
         for (int r = 0; r < KH; r++)
            for (int j = 0; j < KW; j++) win[r][j] <= win_next[r*KW+j];
      end
   end
endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KH x KW convolution with KERNELS loadable kernels, stride and backpressure.
// Optional CONV_RELU_EN clamps negative kernel results to zero before the output register.
module conv_stream_engine
   import conv_pkg::*;
#(
   parameter int KERNELS    = DEF_KERNELS,
   parameter int KH         = DEF_KH,
   parameter int KW         = DEF_KW,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int IMAGE_ROWS = DEF_IMAGE_ROWS,
   parameter int IMAGE_COLS = DEF_IMAGE_COLS,
   parameter int STRIDE     = DEF_STRIDE
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             w_valid,
   input  logic [clog2_1(KERNELS)-1:0]      w_kernel,
   input  logic [clog2_1(KH*KW)-1:0]        w_idx,
   input  logic [DATA_WIDTH-1:0]            w_data,
   output logic                             busy,
   output logic                             done,
   conv_stream_engine_if.slave              strm
);
   localparam int TAPS  = KH*KW;
   localparam int ACC_W = acc_width(DATA_WIDTH, TAPS);
   localparam int OHW   = clog2_1(out_dim(IMAGE_ROWS, KH, STRIDE));
   localparam int OWW   = clog2_1(out_dim(IMAGE_COLS, KW, STRIDE));
   localparam int RW    = clog2_1(IMAGE_ROWS);
   localparam int CW    = clog2_1(IMAGE_COLS);
   localparam logic [RW-1:0] R_LAST  = RW'(IMAGE_ROWS-1);
   localparam logic [RW-1:0] R_FIRST = RW'(KH-1);
   localparam logic [RW-1:0] R_STEP  = RW'(STRIDE);
   localparam logic [CW-1:0] C_LAST  = CW'(IMAGE_COLS-1);
   localparam logic [CW-1:0] C_FIRST = CW'(KW-1);
   localparam logic [CW-1:0] C_STEP  = CW'(STRIDE);

   conv_state_e state, state_nx;
   logic [RW-1:0] row, row_off;
   logic [CW-1:0] col, col_off;
   logic          accept, emit, last_pix;
   logic [DATA_WIDTH-1:0]            wts [KERNELS][TAPS];
   logic [TAPS-1:0][DATA_WIDTH-1:0]  win;
   logic [KERNELS*DATA_WIDTH-1:0]    res;
   logic                             out_valid_q;
   logic [KERNELS*DATA_WIDTH-1:0]    out_data_q;
   logic [OHW-1:0]                   out_row_q;
   logic [OWW-1:0]                   out_col_q;

   assign strm.pix_ready = (state == RUN) && !(out_valid_q && !strm.out_ready);
   assign strm.out_valid = out_valid_q;
   assign strm.out_data  = out_data_q;
   assign strm.out_row   = out_row_q;
   assign strm.out_col   = out_col_q;

   assign accept   = strm.pix_valid && strm.pix_ready;
   assign row_off  = row - R_FIRST;
   assign col_off  = col - C_FIRST;
   assign last_pix = accept && (row == R_LAST) && (col == C_LAST);
   assign emit     = accept && (row >= R_FIRST) && (col >= C_FIRST) &&
                     ((row_off % R_STEP) == '0) && ((col_off % C_STEP) == '0);

   always_comb begin
      state_nx = state;
      busy     = 1'b1;
      done     = 1'b0;
      case (state)
         IDLE:    begin busy = 1'b0; if (start) state_nx = RUN; end
         RUN:     if (last_pix) state_nx = DRAIN;
         DRAIN:   if (!out_valid_q || strm.out_ready) state_nx = DONE;
         DONE:    begin done = 1'b1; state_nx = IDLE; end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
         end else if (accept) begin
            if (col == C_LAST) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Weights are only writable between frames so a running frame sees one kernel set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < KERNELS; k++)
            for (int t = 0; t < TAPS; t++) wts[k][t] <= '0;
      end else if (w_valid && state == IDLE && int'(w_kernel) < KERNELS && int'(w_idx) < TAPS) begin
         wts[w_kernel][w_idx] <= w_data;
      end
   end

   conv_line_buffer #(
      .KH(KH), .KW(KW), .DATA_WIDTH(DATA_WIDTH), .IMAGE_COLS(IMAGE_COLS)
   ) u_lb (
      .clk(clk), .rst(rst), .shift(accept), .col(col), .pix(strm.pix_data), .win_next(win)
   );

   always_comb begin
      logic signed [ACC_W-1:0] sum;
      res = '0;
      for (int k = 0; k < KERNELS; k++) begin
         sum = '0;
         for (int t = 0; t < TAPS; t++)
            sum = sum + ACC_W'(signed'(win[t])) * ACC_W'(signed'(wts[k][t]));
         res[k*DATA_WIDTH +: DATA_WIDTH] = sum[DATA_WIDTH-1:0];
`ifdef CONV_RELU_EN
         if (sum[DATA_WIDTH-1]) res[k*DATA_WIDTH +: DATA_WIDTH] = '0;
`endif
      end
   end

   // A new word may load in the same cycle the held word retires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
      end else if (emit) begin
         out_valid_q <= 1'b1;
         out_data_q  <= res;
         out_row_q   <= OHW'(row_off / R_STEP);
         out_col_q   <= OWW'(col_off / C_STEP);
      end else if (strm.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine: table of frame scenarios checked against a scoreboard
// fed by a direct 2-D convolution model, plus stride-2, reset-abort and zero-weight sequences.
module tb_conv_stream_engine;
   import conv_pkg::*;

   localparam int K  = DEF_KERNELS;
   localparam int KH = DEF_KH;
   localparam int KW = DEF_KW;
   localparam int DW = DEF_DATA_WIDTH;
   localparam int IR = DEF_IMAGE_ROWS;
   localparam int IC = DEF_IMAGE_COLS;
   localparam int OH = 26, OW = 26, OH2 = 13, OW2 = 13;
   localparam int IMG_RAMP = 0, IMG_RAND = 1, IMG_POS = 2, IMG_ONES = 3;
   localparam int KER_IDENT = 0, KER_RAND = 1, KER_NEG = 2, KER_ONES = 3, KER_ZERO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0;
   logic w_valid = 1'b0;
   logic [1:0] w_kernel = '0;
   logic [3:0] w_idx = '0;
   logic [DW-1:0] w_data = '0;
   logic busy_a, done_a, busy_b, done_b;
   logic pv = 1'b0;
   logic [DW-1:0] pd = '0;
   logic ordy = 1'b1;
   bit stall_mode = 1'b0;
   int cyc = 0;

   always #5 clk = ~clk;

   conv_stream_engine_if #(.DATA_WIDTH(DW), .KERNELS(K), .ROW_W(5), .COL_W(5)) ifa ();
   conv_stream_engine_if #(.DATA_WIDTH(DW), .KERNELS(K), .ROW_W(4), .COL_W(4)) ifb ();
   assign ifa.pix_valid = pv;
   assign ifa.pix_data  = pd;
   assign ifa.out_ready = ordy;
   assign ifb.pix_valid = pv;
   assign ifb.pix_data  = pd;
   assign ifb.out_ready = 1'b1;

   conv_stream_engine #(.STRIDE(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .w_valid(w_valid), .w_kernel(w_kernel),
      .w_idx(w_idx), .w_data(w_data), .busy(busy_a), .done(done_a), .strm(ifa));
   conv_stream_engine #(.STRIDE(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .w_valid(w_valid), .w_kernel(w_kernel),
      .w_idx(w_idx), .w_data(w_data), .busy(busy_b), .done(done_b), .strm(ifb));

   typedef struct {
      logic [4:0]        row;
      logic [4:0]        col;
      logic [K*DW-1:0]   data;
   } exp_t;
   typedef struct {
      string name;
      int    img;
      int    ker;
      bit    stall;
      bit    wrun;
      int    n_out;
   } vec_t;

   exp_t q[$];
   int   img [IR][IC];
   logic [DW-1:0] wt [K][KH*KW];
   int   cur_ker;
   int   n_chk = 0, n_fail = 0;
   int   n_out_a = 0, n_out_b = 0, done_cnt_a = 0, done_cnt_b = 0;
   bit   held_v = 1'b0;
   logic [127:0] held;
   logic [3:0] b_r = '0, b_c = '0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      ordy = stall_mode ? (cyc % 4 == 0) : 1'b1;
   end

   function automatic logic [K*DW-1:0] expect_word(input int r0, input int c0, input int ker);
      logic [K*DW-1:0] v;
      logic [DW-1:0]   w;
      longint          acc;
      v = '0;
      for (int k = 0; k < K; k++) begin
         if (ker == KER_IDENT) begin
            w = img[r0+1][c0+1];
         end else begin
            acc = 0;
            for (int i = 0; i < KH; i++)
               for (int j = 0; j < KW; j++)
                  acc += longint'(img[r0+i][c0+j]) * longint'($signed(wt[k][i*KW+j]));
            w = acc[DW-1:0];
         end
`ifdef CONV_RELU_EN
         if (w[DW-1]) w = '0;
`endif
         v[k*DW +: DW] = w;
      end
      return v;
   endfunction

   task automatic fill_img(input int mode);
      for (int r = 0; r < IR; r++)
         for (int c = 0; c < IC; c++)
            case (mode)
               IMG_RAMP: img[r][c] = r*IC + c;
               IMG_RAND: img[r][c] = int'($urandom);
               IMG_POS:  img[r][c] = int'($urandom_range(1000, 1));
               default:  img[r][c] = 1;
            endcase
   endtask

   task automatic load_weights(input int ker);
      cur_ker = ker;
      for (int k = 0; k < K; k++)
         for (int t = 0; t < KH*KW; t++)
            case (ker)
               KER_IDENT: wt[k][t] = (t == 4) ? 32'd1 : 32'd0;
               KER_RAND:  wt[k][t] = $urandom;
               KER_NEG:   wt[k][t] = '1;
               KER_ONES:  wt[k][t] = 32'd1;
               default:   wt[k][t] = '0;
            endcase
      if (ker == KER_ZERO) return;
      for (int k = 0; k < K; k++)
         for (int t = 0; t < KH*KW; t++) begin
            w_valid = 1'b1; w_kernel = 2'(k); w_idx = 4'(t); w_data = wt[k][t];
            tick();
         end
      w_valid = 1'b0;
   endtask

   task automatic drive(input bit use_b, input int npix, input bit wrun);
      int n;
      for (int p = 0; p < npix; p++) begin
         int r, c;
         r = p / IC;
         c = p % IC;
         pv = 1'b1;
         pd = img[r][c];
         if (wrun && p == 100) begin
            w_valid = 1'b1; w_kernel = 2'd0; w_idx = 4'd4; w_data = 32'h7;
         end
         n = 0;
         forever begin
            @(negedge clk);
            if (use_b ? ifb.pix_ready : ifa.pix_ready) break;
            if (++n > 100) begin
               chk("pix_ready_timeout", 0, 1);
               pv = 1'b0;
               w_valid = 1'b0;
               return;
            end
         end
         if (!use_b && r >= KH-1 && c >= KW-1)
            q.push_back('{5'(r-KH+1), 5'(c-KW+1), expect_word(r-KH+1, c-KW+1, cur_ker)});
         tick();
         w_valid = 1'b0;
      end
      pv = 1'b0;
   endtask

   task automatic run_frame(input vec_t v);
      int d0, n;
      fill_img(v.img);
      load_weights(v.ker);
      stall_mode = v.stall;
      n_out_a = 0;
      d0 = done_cnt_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      drive(1'b0, IR*IC, v.wrun);
      n = 0;
      while (done_cnt_a == d0 && n < 5000) begin tick(); n++; end
      repeat (5) tick();
      chk({v.name, "_done_pulses"}, done_cnt_a - d0, 1);
      chk({v.name, "_out_count"}, n_out_a, v.n_out);
      chk({v.name, "_sb_empty"}, q.size(), 0);
      chk({v.name, "_idle"}, busy_a, 0);
      stall_mode = 1'b0;
   endtask

   // Scoreboard and stall-stability monitor for the stride-1 engine.
   always @(negedge clk) begin
      if (!rst) begin
         exp_t e;
         if (held_v && ifa.out_valid)
            chk("hold_stable", {ifa.out_row, ifa.out_col, ifa.out_data}, held);
         if (ifa.out_valid && !ifa.out_ready) chk("pix_ready_stall", ifa.pix_ready, 0);
         held_v = ifa.out_valid && !ifa.out_ready;
         held   = {ifa.out_row, ifa.out_col, ifa.out_data};
         if (ifa.out_valid && ifa.out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               e = q.pop_front();
               chk("out_word", {ifa.out_row, ifa.out_col, ifa.out_data}, {e.row, e.col, e.data});
               n_out_a++;
            end
         end
         if (done_a) begin
            done_cnt_a++;
            chk("done_after_last", q.size(), 0);
         end
      end
   end

   // Stride-2 engine: all-ones data, so every word is 9 and positions walk the 13x13 grid.
   always @(negedge clk) begin
      if (!rst) begin
         if (ifb.out_valid) begin
            for (int k = 0; k < K; k++) chk("stride_value", ifb.out_data[k*DW +: DW], 9);
            chk("stride_pos", {ifb.out_row, ifb.out_col}, {b_r, b_c});
            if (b_c == 4'(OW2-1)) begin b_c = '0; b_r = b_r + 1'b1; end
            else b_c = b_c + 1'b1;
            n_out_b++;
         end
         if (done_b) done_cnt_b++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[5];
      int d0, n;
      vt[0] = '{"identity_ramp",  IMG_RAMP, KER_IDENT, 1'b0, 1'b0, OH*OW};
      vt[1] = '{"random_wrap",    IMG_RAND, KER_RAND,  1'b0, 1'b0, OH*OW};
      vt[2] = '{"stall_1on3off",  IMG_RAND, KER_RAND,  1'b1, 1'b0, OH*OW};
      vt[3] = '{"w_write_in_run", IMG_RAND, KER_RAND,  1'b0, 1'b1, OH*OW};
      vt[4] = '{"neg_kernel",     IMG_POS,  KER_NEG,   1'b0, 1'b0, OH*OW};

      repeat (3) tick();
      chk("rst_out_valid", ifa.out_valid, 0);
      chk("rst_out_data", ifa.out_data, 0);
      chk("rst_out_pos", {ifa.out_row, ifa.out_col}, 0);
      chk("rst_pix_ready", ifa.pix_ready, 0);
      chk("rst_busy_done", {busy_a, done_a}, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_frame(vt[i]);

      // Stride 2 on a 28x28 all-ones image with all-ones kernels.
      fill_img(IMG_ONES);
      load_weights(KER_ONES);
      d0 = done_cnt_b;
      start_b = 1'b1; tick(); start_b = 1'b0;
      drive(1'b1, IR*IC, 1'b0);
      n = 0;
      while (done_cnt_b == d0 && n < 2000) begin tick(); n++; end
      repeat (3) tick();
      chk("stride_out_count", n_out_b, OH2*OW2);
      chk("stride_done_pulses", done_cnt_b - d0, 1);

      // Reset part-way through a frame: everything returns to zero and no done follows.
      fill_img(IMG_RAND);
      load_weights(KER_RAND);
      start_a = 1'b1; tick(); start_a = 1'b0;
      drive(1'b0, 300, 1'b0);
      d0 = done_cnt_a;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", ifa.out_valid, 0);
      chk("midrst_out_data", ifa.out_data, 0);
      chk("midrst_pix_ready", ifa.pix_ready, 0);
      chk("midrst_busy", busy_a, 0);
      q.delete();
      held_v = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      repeat (20) tick();
      chk("midrst_no_done", done_cnt_a - d0, 0);
      chk("midrst_idle", busy_a, 0);

      // Reset cleared the weights, so a frame without reloading yields zeros.
      run_frame('{"zero_after_rst", IMG_RAND, KER_ZERO, 1'b0, 1'b0, OH*OW});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
